nand_resp_checker: RTL and testbench
====================================

Name: nand_resp_checker

Overview:
- Response-side counterpart of the N-input NAND stimulus sequence: receives each applied input vector plus the DUT output and checks the output against the expected NAND value.
- Waits a programmable settle time per vector, then compares, counts errors and records the first failing vector.
- Reports done/pass once all 2^N_IN vectors have been checked.
- Sits beside the NAND DUT in synthesizable self-check harnesses, in place of waveform inspection.

Parameters:
- N_IN, 4, NAND input count; vector space is 2^N_IN.
- SETTLE, 2, clk cycles between vector capture and sampling y_obs; legal range 1..15.
- CNT_W, 8, width of err_cnt and chk_cnt; must satisfy 2^CNT_W > 2^N_IN.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a check run from IDLE or DONE.
- vec_valid  in  1  vec is applied to the DUT this cycle.
- vec  in  N_IN  applied DUT input vector, {a,b,c,d} order, MSB = a.
- y_obs  in  1  observed DUT output.
- busy  out  1  run in progress.
- done  out  1  run complete; held until next start.
- pass  out  1  valid when done; 1 iff err_cnt==0, no overrun and (with the feature) full coverage.
- err_cnt  out  CNT_W  mismatch count, saturating.
- chk_cnt  out  CNT_W  number of compares performed.
- first_fail_vld  out  1  first_fail_vec holds a captured failure.
- first_fail_vec  out  N_IN  vector of the first mismatch.
- overrun  out  1  sticky; vec_valid arrived while not in ARMED.

Behaviour:
- Reset (async on rst_n=0): state IDLE; every output 0; settle counter 0.
- Reset mid-run discards all results. No partial done is produced.
- FSM states: IDLE, ARMED, SETTLE, DONE (encoding held in the package).
- IDLE or DONE, start=1: clear err_cnt, chk_cnt, first_fail_*, overrun and coverage; next cycle is ARMED with busy=1 and done=0.
- ARMED, vec_valid=1: latch vec into vec_q, load the settle counter with SETTLE-1, go to SETTLE.
- SETTLE: decrement the counter each cycle. On the cycle the counter is 0:
  - expected = ~&vec_q;
  - compare with y_obs;
  - chk_cnt += 1;
  - on mismatch, err_cnt += 1 (saturating at all-ones);
  - if first_fail_vld is 0, capture vec_q and set first_fail_vld.
- After the compare:
  - if the completion condition is met, go to DONE (busy=0, done=1, pass registered that same edge);
  - otherwise return to ARMED.
- Latency: a vector captured at edge k is compared at edge k+SETTLE. Outputs update at edge k+SETTLE.
- vec_valid in SETTLE: ignored, overrun set (sticky).
- vec_valid in IDLE or DONE: ignored, no flag.
- start in ARMED or SETTLE: ignored.
- start and vec_valid in the same cycle while in IDLE: start wins, the vector is dropped.
- Completion without the feature: chk_cnt reaches 2^N_IN.

Optional Feature:
- Macro: NAND_CHK_COVERAGE_EN.
- Defined:
  - Keep a 2^N_IN-bit seen bitmap, set at index vec_q on each compare.
  - Completion occurs when the bitmap is all ones.
  - chk_cnt saturates at all-ones and does not wrap.
  - Duplicate vectors are compared and counted but do not advance coverage.
  - pass additionally requires full coverage.
- Undefined: no bitmap logic; completion is by count only, so duplicates can mask missing vectors.

Decomposition:
- Package nand_chk_pkg:
  - state encoding (2-bit localparams IDLE=0, ARMED=1, SETTLE=2, DONE=3);
  - function nand_exp(vec) returning ~&vec;
  - localparam VEC_SPACE = 1<<N_IN.
- Sub-module nand_settle_timer:
  - 4-bit down counter with load and expire outputs;
  - instantiated once.

Test Plan:
- Correct DUT: reset, start, then drive all 16 vectors 0000..1111 with a 100-cycle gap each; y_obs = ~&vec. Expect done=1, pass=1, err_cnt=0, chk_cnt=16, first_fail_vld=0.
- Stuck-at-1 DUT: y_obs=1 for the same sweep. Expect err_cnt=1, first_fail_vec=4'b1111, pass=0.
- Overrun: send vec_valid on back-to-back cycles with SETTLE=2. Expect the second vector ignored, overrun=1, and pass=0 at completion.
- Duplicates with NAND_CHK_COVERAGE_EN: send 0000 twice, then 0001..1110 (15 distinct vectors). Expect done to stay 0. Send 1111: expect done=1, chk_cnt=17.
- Reset mid-run: assert rst_n=0 after 5 vectors. Expect all outputs 0 immediately (asynchronously). Then start and run a full sweep: expect a clean pass.
- Restart from DONE: after a failing run, pulse start. Expect err_cnt, first_fail_* and overrun cleared the next cycle, and busy=1.

Source files
------------

// File: rtl/nand_chk_pkg.sv
// rtl/nand_chk_pkg.sv - shared state encoding and expected-value helper for the NAND response checker
package nand_chk_pkg;

   // Checker FSM encoding
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_DONE   = 2'd3
   } chk_state_t;

   // Default NAND width and the size of its exhaustive vector space
   localparam int NAND_N_IN = 4;
   localparam int VEC_SPACE = 1 << NAND_N_IN;

   // Expected NAND output for the low n bits of vec; unused upper bits are forced to 1
   function automatic logic nand_exp(input logic [31:0] vec, input int n);
      logic [31:0] mask;
      mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
      return ~&(vec | ~mask);
   endfunction

endpackage

// File: rtl/nand_settle_timer.sv
// rtl/nand_settle_timer.sv - 4-bit loadable down counter that flags when the settle time has elapsed
module nand_settle_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       expire
);

   logic [3:0] cnt;

   // Load has priority; decrement stops at zero so the counter never wraps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 4'd0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != 4'd0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   assign expire = (cnt == 4'd0);

endmodule

// File: rtl/nand_resp_checker.sv
// rtl/nand_resp_checker.sv - checks NAND DUT responses per applied vector; optional NAND_CHK_COVERAGE_EN adds a seen-vector bitmap
module nand_resp_checker
   import nand_chk_pkg::*;
#(
   parameter int N_IN   = 4,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             vec_valid,
   input  logic [N_IN-1:0]  vec,
   input  logic             y_obs,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] chk_cnt,
   output logic             first_fail_vld,
   output logic [N_IN-1:0]  first_fail_vec,
   output logic             overrun
);

   localparam int               N_VEC       = 1 << N_IN;
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_DONE    = CNT_W'(N_VEC);
   localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);

   chk_state_t       state;
   logic [N_IN-1:0]  vec_q;

   logic             tmr_load;
   logic             tmr_dec;
   logic             tmr_expire;

   logic             compare;
   logic             exp_y;
   logic             mismatch;
   logic [CNT_W-1:0] chk_next;
   logic [CNT_W-1:0] err_next;
   logic             ovr_next;
   logic             complete;
   logic             cov_ok;

   // Timer is loaded as a vector is accepted and counts down while settling
   assign tmr_load = (state == ST_ARMED) && vec_valid;
   assign tmr_dec  = (state == ST_SETTLE) && !tmr_expire;

   nand_settle_timer u_settle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (SETTLE_LOAD),
      .dec      (tmr_dec),
      .expire   (tmr_expire)
   );

   // Compare happens on the settle cycle whose counter value is zero
   assign compare  = (state == ST_SETTLE) && tmr_expire;
   assign exp_y    = nand_exp(32'(vec_q), N_IN);
   assign mismatch = (y_obs != exp_y);
   assign chk_next = (chk_cnt == CNT_MAX) ? chk_cnt : chk_cnt + CNT_W'(1);
   assign err_next = (mismatch && (err_cnt != CNT_MAX)) ? err_cnt + CNT_W'(1) : err_cnt;
   // A vector arriving while a previous one is still settling is lost
   assign ovr_next = overrun | ((state == ST_SETTLE) && vec_valid);

`ifdef NAND_CHK_COVERAGE_EN
   logic [N_VEC-1:0] seen;
   logic [N_VEC-1:0] seen_next;

   assign seen_next = seen | (N_VEC'(1) << vec_q);
   assign complete  = &seen_next;
   assign cov_ok    = &seen_next;

   // Seen bitmap: cleared on a new run, marked on every compare
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen <= '0;
      end else if (((state == ST_IDLE) || (state == ST_DONE)) && start) begin
         seen <= '0;
      end else if (compare) begin
         seen <= seen_next;
      end
   end
`else
   assign complete = (chk_next == CNT_DONE);
   assign cov_ok   = 1'b1;
`endif

   // Run control FSM with all result outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         vec_q          <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_cnt        <= '0;
         chk_cnt        <= '0;
         first_fail_vld <= 1'b0;
         first_fail_vec <= '0;
         overrun        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state          <= ST_ARMED;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  err_cnt        <= '0;
                  chk_cnt        <= '0;
                  first_fail_vld <= 1'b0;
                  first_fail_vec <= '0;
                  overrun        <= 1'b0;
               end
            end
            ST_ARMED: begin
               if (vec_valid) begin
                  vec_q <= vec;
                  state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               overrun <= ovr_next;
               if (compare) begin
                  chk_cnt <= chk_next;
                  err_cnt <= err_next;
                  if (mismatch && !first_fail_vld) begin
                     first_fail_vld <= 1'b1;
                     first_fail_vec <= vec_q;
                  end
                  if (complete) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_next == '0) && !ovr_next && cov_ok;
                  end else begin
                     state <= ST_ARMED;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nand_resp_checker.sv
// tb/tb_nand_resp_checker.sv - directed self-checking bench for nand_resp_checker
module tb_nand_resp_checker;

   localparam int GAP = 100;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       vec_valid;
   logic [3:0] vec;
   logic       y_obs;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_cnt;
   logic [7:0] chk_cnt;
   logic       first_fail_vld;
   logic [3:0] first_fail_vec;
   logic       overrun;

   int n_assert = 0;
   int n_fail   = 0;

   nand_resp_checker #(.N_IN(4), .SETTLE(2), .CNT_W(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .vec_valid      (vec_valid),
      .vec            (vec),
      .y_obs          (y_obs),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_cnt        (err_cnt),
      .chk_cnt        (chk_cnt),
      .first_fail_vld (first_fail_vld),
      .first_fail_vec (first_fail_vec),
      .overrun        (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic apply_vec(input logic [3:0] v, input logic stuck);
      @(posedge clk);
      #1;
      vec       = v;
      y_obs     = stuck ? 1'b1 : ~&v;
      vec_valid = 1'b1;
      @(posedge clk);
      #1 vec_valid = 1'b0;
      tick(GAP);
   endtask

   task automatic sweep(input logic stuck);
      for (int i = 0; i < 16; i++) apply_vec(4'(i), stuck);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; vec_valid = 1'b0; vec = 4'd0; y_obs = 1'b0;
      tick(3);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_err", 32'(err_cnt), 32'd0);
      check("rst_chk", 32'(chk_cnt), 32'd0);
      check("rst_ffv", 32'(first_fail_vld), 32'd0);
      check("rst_ovr", 32'(overrun), 32'd0);
      rst_n = 1'b1;

      // start and vec_valid together in IDLE: start wins, vector dropped
      @(posedge clk);
      #1; start = 1'b1; vec_valid = 1'b1; vec = 4'd0; y_obs = 1'b0;
      @(posedge clk);
      #1; start = 1'b0; vec_valid = 1'b0;
      tick(5);
      check("startvec_busy", 32'(busy), 32'd1);
      check("startvec_chk", 32'(chk_cnt), 32'd0);
      check("startvec_ovr", 32'(overrun), 32'd0);

      // Correct DUT sweep
      sweep(1'b0);
      check("good_done", 32'(done), 32'd1);
      check("good_pass", 32'(pass), 32'd1);
      check("good_busy", 32'(busy), 32'd0);
      check("good_err", 32'(err_cnt), 32'd0);
      check("good_chk", 32'(chk_cnt), 32'd16);
      check("good_ffv", 32'(first_fail_vld), 32'd0);

      // Stuck-at-1 DUT: only 1111 mismatches
      pulse_start();
      sweep(1'b1);
      check("stuck_done", 32'(done), 32'd1);
      check("stuck_pass", 32'(pass), 32'd0);
      check("stuck_err", 32'(err_cnt), 32'd1);
      check("stuck_ffv", 32'(first_fail_vld), 32'd1);
      check("stuck_ffvec", 32'(first_fail_vec), 32'hF);

      // Restart from DONE clears results
      pulse_start();
      check("restart_busy", 32'(busy), 32'd1);
      check("restart_done", 32'(done), 32'd0);
      check("restart_err", 32'(err_cnt), 32'd0);
      check("restart_ffv", 32'(first_fail_vld), 32'd0);
      check("restart_ffvec", 32'(first_fail_vec), 32'd0);
      check("restart_chk", 32'(chk_cnt), 32'd0);

      // Overrun: back-to-back vec_valid, second vector dropped
      @(posedge clk);
      #1; vec = 4'd0; y_obs = 1'b1; vec_valid = 1'b1;
      @(posedge clk);
      #1; vec = 4'd1;
      @(posedge clk);
      #1; vec_valid = 1'b0;
      check("ovr_flag", 32'(overrun), 32'd1);
      tick(10);
      check("ovr_chk_one", 32'(chk_cnt), 32'd1);
      tick(GAP);
      for (int i = 1; i < 16; i++) apply_vec(4'(i), 1'b0);
      check("ovr_done", 32'(done), 32'd1);
      check("ovr_pass", 32'(pass), 32'd0);
      check("ovr_err", 32'(err_cnt), 32'd0);
      check("ovr_chk", 32'(chk_cnt), 32'd16);
      check("ovr_sticky", 32'(overrun), 32'd1);

      pulse_start();
      check("restart_ovr", 32'(overrun), 32'd0);

      // Duplicate vector 0000, then 0001..1110
      apply_vec(4'd0, 1'b0);
      for (int i = 0; i < 15; i++) apply_vec(4'(i), 1'b0);
`ifdef NAND_CHK_COVERAGE_EN
      check("dup_not_done", 32'(done), 32'd0);
      check("dup_chk16", 32'(chk_cnt), 32'd16);
      apply_vec(4'hF, 1'b0);
      check("dup_done", 32'(done), 32'd1);
      check("dup_chk17", 32'(chk_cnt), 32'd17);
      check("dup_pass", 32'(pass), 32'd1);
`else
      check("dup_done_by_count", 32'(done), 32'd1);
      check("dup_chk16", 32'(chk_cnt), 32'd16);
      check("dup_pass", 32'(pass), 32'd1);
`endif

      // Reset mid-run after 5 vectors (one failing)
      pulse_start();
      apply_vec(4'hF, 1'b1);
      for (int i = 0; i < 4; i++) apply_vec(4'(i), 1'b0);
      check("mid_pre_chk", 32'(chk_cnt), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_err", 32'(err_cnt), 32'd0);
      check("mid_chk", 32'(chk_cnt), 32'd0);
      check("mid_ffv", 32'(first_fail_vld), 32'd0);
      check("mid_ffvec", 32'(first_fail_vec), 32'd0);
      check("mid_done", 32'(done), 32'd0);
      tick(2);
      rst_n = 1'b1;
      pulse_start();
      sweep(1'b0);
      check("post_done", 32'(done), 32'd1);
      check("post_pass", 32'(pass), 32'd1);
      check("post_chk", 32'(chk_cnt), 32'd16);
      check("post_err", 32'(err_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
